// File: rtl/memory_stage.sv
`default_nettype none
// ============================================================================
// Module  : memory_stage
// Brief   : Y86-64 Memory stage. Issues data-memory reads/writes over a
//           req/ack handshake, stalls upstream while an access is pending,
//           and owns the M/W pipeline register feeding Writeback.
// Revision: 1.0 - initial release
// ============================================================================
module memory_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        M_valid,
  input  logic [2:0]  M_stat,
  input  logic [3:0]  M_icode,
  input  logic        M_Cnd,
  input  logic [63:0] M_valE,
  input  logic [63:0] M_valA,
  input  logic [3:0]  M_dstE,
  input  logic [3:0]  M_dstM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic        dmem_err,
  input  logic [63:0] dmem_rdata,
  output logic        m_busy,
  output logic [2:0]  W_stat,
  output logic [3:0]  W_icode,
  output logic        W_Cnd,
  output logic [63:0] W_valE,
  output logic [63:0] W_valM,
  output logic [3:0]  W_dstE,
  output logic [3:0]  W_dstM
);

  localparam logic [2:0]       c_SAOK     = 3'd1;
  localparam logic [2:0]       c_SADR     = 3'd3;
  localparam logic [3:0]       c_RNONE    = 4'hF;
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valM;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
  } wreg_t;

  // Bubble doubles as the reset image of the M/W register.
  localparam wreg_t c_BUBBLE = '{stat: 3'd1, icode: 4'h1, cnd: 1'b0,
                                 valE: 64'd0, valM: 64'd0,
                                 dstE: 4'hF, dstM: 4'hF};

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_req;
  logic             r_we;
  logic [63:0]      r_addr;
  logic [63:0]      r_wdata;
  wreg_t            r_W;

  logic             w_is_rd;
  logic             w_is_wr;
  logic             w_frozen;
  logic             w_qual;
  logic             w_timeout;
  logic             w_done_ok;
  logic             w_abort;
  logic [63:0]      w_addr;
  wreg_t            w_from_m;

  // Stack pops (ret/popq) address through valA; everything else via valE.
  assign w_is_rd   = (M_icode == 4'h5) || (M_icode == 4'h9) || (M_icode == 4'hB);
  assign w_is_wr   = (M_icode == 4'h4) || (M_icode == 4'h8) || (M_icode == 4'hA);
  assign w_addr    = ((M_icode == 4'h9) || (M_icode == 4'hB)) ? M_valA : M_valE;
  assign w_frozen  = (r_W.stat != c_SAOK);
  assign w_qual    = M_valid && (M_stat == c_SAOK) && !w_frozen && (w_is_rd || w_is_wr);
  assign w_timeout = (r_cnt == c_CNT_LAST);
  assign w_done_ok = dmem_ack && !dmem_err;
  assign w_abort   = (dmem_ack && dmem_err) || (!dmem_ack && w_timeout);
  assign w_from_m  = '{stat: M_stat, icode: M_icode, cnd: M_Cnd,
                       valE: M_valE, valM: 64'd0,
                       dstE: M_dstE, dstM: M_dstM};

  // Stall upstream while issuing, while waiting, and forever once frozen.
  always_comb begin
    m_busy = 1'b0;
    unique case (r_state)
      S_IDLE:  m_busy = w_frozen || w_qual;
      S_WAIT:  m_busy = !dmem_ack && !w_timeout;
      default: m_busy = 1'b0;
    endcase
  end

  // Access FSM, memory request registers and M/W pipeline register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= 64'd0;
      r_wdata <= 64'd0;
      r_W     <= c_BUBBLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          // A faulted W register must never be overwritten, so nothing moves.
          if (!w_frozen) begin
            if (w_qual) begin
              r_req   <= 1'b1;
              r_we    <= w_is_wr;
              r_addr  <= w_addr;
              r_wdata <= M_valA;
              r_state <= S_WAIT;
              r_W     <= c_BUBBLE;
            end else if (!M_valid) begin
              r_W <= c_BUBBLE;
            end else begin
              r_W <= w_from_m;
            end
          end
        end
        S_WAIT: begin
          if (w_done_ok) begin
            r_req   <= 1'b0;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_W     <= w_from_m;
            r_W.valM <= r_we ? 64'd0 : dmem_rdata;
          end else if (w_abort) begin
            r_req   <= 1'b0;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_W      <= w_from_m;
            r_W.stat <= c_SADR;
            r_W.dstE <= c_RNONE;
            r_W.dstM <= c_RNONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dmem_req   = r_req;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;
  assign W_stat     = r_W.stat;
  assign W_icode    = r_W.icode;
  assign W_Cnd      = r_W.cnd;
  assign W_valE     = r_W.valE;
  assign W_valM     = r_W.valM;
  assign W_dstE     = r_W.dstE;
  assign W_dstM     = r_W.dstM;

endmodule
`default_nettype wire

// File: tb/tb_memory_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_memory_stage
// Brief   : Directed bench for memory_stage with a transaction-level model
//           of the stage and a per-cycle compare process.
// Revision: 1.0 - initial release
// ============================================================================
module tb_memory_stage;

  localparam int TIMEOUT = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        M_valid;
  logic [2:0]  M_stat;
  logic [3:0]  M_icode;
  logic        M_Cnd;
  logic [63:0] M_valE, M_valA;
  logic [3:0]  M_dstE, M_dstM;
  logic        dmem_req, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata;
  logic        dmem_ack, dmem_err;
  logic [63:0] dmem_rdata;
  logic        m_busy;
  logic [2:0]  W_stat;
  logic [3:0]  W_icode;
  logic        W_Cnd;
  logic [63:0] W_valE, W_valM;
  logic [3:0]  W_dstE, W_dstM;

  memory_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clock(clock), .reset(reset),
    .M_valid(M_valid), .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd),
    .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_err(dmem_err),
    .dmem_rdata(dmem_rdata), .m_busy(m_busy),
    .W_stat(W_stat), .W_icode(W_icode), .W_Cnd(W_Cnd), .W_valE(W_valE),
    .W_valM(W_valM), .W_dstE(W_dstE), .W_dstM(W_dstM)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  // Model expectations for the current cycle.
  logic        chk_en = 1'b0;
  logic        exp_busy, exp_req, exp_we;
  logic [63:0] exp_addr, exp_wdata;
  logic [2:0]  e_stat;
  logic [3:0]  e_icode, e_dstE, e_dstM;
  logic        e_cnd;
  logic [63:0] e_valE, e_valM;

  // Observation counters maintained by the compare process.
  int          busy_total = 0;
  int          req_total  = 0;
  logic [63:0] last_addr  = 64'd0;
  logic [63:0] last_wdata = 64'd0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic set_w(input logic [2:0] st, input logic [3:0] ic, input logic cnd,
                       input logic [63:0] ve, input logic [63:0] vm,
                       input logic [3:0] de, input logic [3:0] dm);
    e_stat = st; e_icode = ic; e_cnd = cnd; e_valE = ve; e_valM = vm;
    e_dstE = de; e_dstM = dm;
  endtask

  task automatic drive_bubble();
    M_valid = 1'b0; M_stat = 3'd1; M_icode = 4'h1; M_Cnd = 1'b0;
    M_valE = 64'd0; M_valA = 64'd0; M_dstE = 4'hF; M_dstM = 4'hF;
    dmem_ack = 1'b0; dmem_err = 1'b0; dmem_rdata = 64'd0;
  endtask

  // Present one instruction and follow it to retirement.
  // lat: WAIT cycle (1-based) in which memory acks; 0 = memory never answers.
  task automatic run_instr(input logic v, input logic [2:0] st, input logic [3:0] ic,
                           input logic cnd, input logic [63:0] ve, input logic [63:0] va,
                           input logic [3:0] de, input logic [3:0] dm,
                           input int lat, input logic err, input logic [63:0] rd);
    logic rdop, wrop, fault;
    logic [63:0] a;
    int endk;
    rdop = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
    wrop = (ic == 4'h4) || (ic == 4'h8) || (ic == 4'hA);
    a    = ((ic == 4'h9) || (ic == 4'hB)) ? va : ve;
    M_valid = v; M_stat = st; M_icode = ic; M_Cnd = cnd;
    M_valE = ve; M_valA = va; M_dstE = de; M_dstM = dm;
    dmem_ack = 1'b0; dmem_err = 1'b0; dmem_rdata = 64'd0;
    if (e_stat != 3'd1) begin
      // Stage is frozen by an earlier fault: held, stalled, silent.
      exp_busy = 1'b1; exp_req = 1'b0;
      repeat (3) cyc();
    end else if (!(v && st == 3'd1 && (rdop || wrop))) begin
      exp_busy = 1'b0; exp_req = 1'b0;
      cyc();
      if (!v) set_w(3'd1, 4'h1, 1'b0, 64'd0, 64'd0, 4'hF, 4'hF);
      else    set_w(st, ic, cnd, ve, 64'd0, de, dm);
    end else begin
      exp_busy = 1'b1; exp_req = 1'b0;
      cyc();
      set_w(3'd1, 4'h1, 1'b0, 64'd0, 64'd0, 4'hF, 4'hF);
      exp_req = 1'b1; exp_we = wrop; exp_addr = a; exp_wdata = va;
      endk  = (lat >= 1 && lat <= TIMEOUT) ? lat : TIMEOUT;
      fault = (endk != lat) || err;
      for (int k = 1; k <= endk; k++) begin
        if (k == lat) begin dmem_ack = 1'b1; dmem_err = err; dmem_rdata = rd; end
        exp_busy = (k == endk) ? 1'b0 : 1'b1;
        cyc();
      end
      dmem_ack = 1'b0; dmem_err = 1'b0; dmem_rdata = 64'd0;
      exp_req = 1'b0;
      if (fault) set_w(3'd3, ic, cnd, ve, 64'd0, 4'hF, 4'hF);
      else       set_w(3'd1, ic, cnd, ve, wrop ? 64'd0 : rd, de, dm);
    end
    drive_bubble();
    exp_busy = (e_stat != 3'd1);
  endtask

  // Pull reset asynchronously between edges and return to a clean stage.
  task automatic do_reset();
    chk_en = 1'b0;
    drive_bubble();
    reset = 1'b0;
    #1;
    chk("rst_req", {63'd0, dmem_req}, 64'd0);
    chk("rst_W_icode", {60'd0, W_icode}, 64'h1);
    chk("rst_W_dstE", {60'd0, W_dstE}, 64'hF);
    chk("rst_W_stat", {61'd0, W_stat}, 64'd1);
    chk("rst_we", {63'd0, dmem_we}, 64'd0);
    chk("rst_addr", dmem_addr, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    cyc();
    set_w(3'd1, 4'h1, 1'b0, 64'd0, 64'd0, 4'hF, 4'hF);
    exp_busy = 1'b0; exp_req = 1'b0; exp_we = 1'b0;
    exp_addr = 64'd0; exp_wdata = 64'd0;
    chk_en = 1'b1;
  endtask

  int b0, r0;

  initial begin
    fork
      forever begin
        @(negedge clock);
        if (m_busy)   busy_total++;
        if (dmem_req) begin req_total++; last_addr = dmem_addr; last_wdata = dmem_wdata; end
        if (chk_en) begin
          chk("m_busy", {63'd0, m_busy}, {63'd0, exp_busy});
          chk("dmem_req", {63'd0, dmem_req}, {63'd0, exp_req});
          if (exp_req) begin
            chk("dmem_we", {63'd0, dmem_we}, {63'd0, exp_we});
            chk("dmem_addr", dmem_addr, exp_addr);
            if (exp_we) chk("dmem_wdata", dmem_wdata, exp_wdata);
          end
          chk("W_stat", {61'd0, W_stat}, {61'd0, e_stat});
          chk("W_icode", {60'd0, W_icode}, {60'd0, e_icode});
          chk("W_Cnd", {63'd0, W_Cnd}, {63'd0, e_cnd});
          chk("W_valE", W_valE, e_valE);
          chk("W_valM", W_valM, e_valM);
          chk("W_dstE", {60'd0, W_dstE}, {60'd0, e_dstE});
          chk("W_dstM", {60'd0, W_dstM}, {60'd0, e_dstM});
        end
      end
    join_none

    drive_bubble();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    do_reset();
    cyc();

    // opq: passes straight through, no stall.
    b0 = busy_total; r0 = req_total;
    run_instr(1, 3'd1, 4'h6, 1'b0, 64'h1234, 64'h9, 4'h3, 4'hF, 0, 0, 64'd0);
    chk("opq_busy", 64'(busy_total - b0), 64'd0);
    chk("opq_noreq", 64'(req_total - r0), 64'd0);
    chk("opq_valE", W_valE, 64'h1234);

    // Bubble and a not-taken cmov.
    run_instr(0, 3'd1, 4'h6, 1'b1, 64'h77, 64'h1, 4'h2, 4'h2, 0, 0, 64'd0);
    run_instr(1, 3'd1, 4'h2, 1'b0, 64'h5A, 64'h5A, 4'h6, 4'hF, 0, 0, 64'd0);

    // mrmovq, ack in the 4th request cycle.
    b0 = busy_total;
    run_instr(1, 3'd1, 4'h5, 1'b0, 64'h100, 64'h999, 4'hF, 4'h7, 4, 0, 64'hDEAD);
    chk("mrm_busy", 64'(busy_total - b0), 64'd4);
    chk("mrm_addr", last_addr, 64'h100);
    chk("mrm_valM", W_valM, 64'hDEAD);
    chk("mrm_dstM", {60'd0, W_dstM}, 64'h7);

    // pushq, ack in first request cycle: one stall cycle, two-cycle latency.
    b0 = busy_total;
    run_instr(1, 3'd1, 4'hA, 1'b0, 64'h1F8, 64'h55, 4'h4, 4'hF, 1, 0, 64'hBAD);
    chk("push_busy", 64'(busy_total - b0), 64'd1);
    chk("push_wdata", last_wdata, 64'h55);
    chk("push_stat", {61'd0, W_stat}, 64'd1);

    // popq addresses through valA, call/ret exercise the stack pair.
    run_instr(1, 3'd1, 4'hB, 1'b0, 64'h208, 64'h200, 4'h4, 4'h5, 2, 0, 64'h77);
    chk("pop_addr", last_addr, 64'h200);
    run_instr(1, 3'd1, 4'h8, 1'b0, 64'h1F0, 64'h40, 4'h4, 4'hF, 3, 0, 64'd0);
    run_instr(1, 3'd1, 4'h9, 1'b0, 64'h1F8, 64'h1F0, 4'h4, 4'hF, 2, 0, 64'h40);
    chk("ret_addr", last_addr, 64'h1F0);

    // Faulting store freezes the stage; the following op is held off.
    run_instr(1, 3'd1, 4'h4, 1'b0, 64'hFFF0, 64'h12, 4'hF, 4'hF, 2, 1, 64'd0);
    chk("err_stat", {61'd0, W_stat}, 64'd3);
    r0 = req_total;
    run_instr(1, 3'd1, 4'h6, 1'b0, 64'h1, 64'h2, 4'h3, 4'hF, 0, 0, 64'd0);
    chk("frz_noreq", 64'(req_total - r0), 64'd0);
    do_reset();

    // Memory never answers: abort after the timeout window.
    b0 = busy_total; r0 = req_total;
    run_instr(1, 3'd1, 4'h5, 1'b0, 64'h300, 64'h0, 4'hF, 4'h2, 0, 0, 64'd0);
    chk("to_req_cycles", 64'(req_total - r0), 64'd16);
    chk("to_busy", 64'(busy_total - b0), 64'd16);
    chk("to_stat", {61'd0, W_stat}, 64'd3);
    r0 = req_total;
    run_instr(1, 3'd1, 4'h4, 1'b0, 64'h400, 64'h9, 4'hF, 4'hF, 1, 0, 64'd0);
    chk("to_nostore", 64'(req_total - r0), 64'd0);
    do_reset();

    // Reset in the middle of an outstanding read.
    M_valid = 1'b1; M_stat = 3'd1; M_icode = 4'h5; M_Cnd = 1'b0;
    M_valE = 64'h180; M_valA = 64'd0; M_dstE = 4'hF; M_dstM = 4'h3;
    exp_busy = 1'b1; exp_req = 1'b0;
    cyc();
    set_w(3'd1, 4'h1, 1'b0, 64'd0, 64'd0, 4'hF, 4'hF);
    chk("mid_req_up", {63'd0, dmem_req}, 64'd1);
    do_reset();
    cyc();

    // Upstream instruction fault: copied to W, no access, then frozen.
    r0 = req_total;
    run_instr(1, 3'd4, 4'h4, 1'b0, 64'h500, 64'h1, 4'hF, 4'hF, 1, 0, 64'd0);
    chk("sins_stat", {61'd0, W_stat}, 64'd4);
    run_instr(1, 3'd1, 4'h5, 1'b0, 64'h600, 64'h0, 4'hF, 4'h1, 1, 0, 64'h9);
    chk("sins_noreq", 64'(req_total - r0), 64'd0);
    chk("sins_busy", {63'd0, m_busy}, 64'd1);

    cyc();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
